// File: rtl/display_pkg.sv
// Shared types and constants for the double-buffered display frame store.
// Used by display_framebuffer (optional clear feature: CLEAR_ON_FLIP_EN) and the scan engine.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        CLEAR   = 2'd2
    } fb_state_e;

    // Bank-select encoding agreed with the scan engine: it always shows the front bank.
    localparam logic FRONT_AT_RESET = 1'b0;
    localparam int unsigned BANK_AW = 1;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic write_bank(input logic front);
        return ~front;
    endfunction

    function automatic logic read_bank(input logic front);
        return front;
    endfunction

endpackage

// File: rtl/display_fb_ram.sv
// Simple dual-port frame RAM: per-segment write mask, registered read, no reset.
module display_fb_ram #(
    parameter int unsigned SEGMENTS = 1,
    parameter int unsigned WIDTH    = 24,
    parameter int unsigned AW       = 9
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [SEGMENTS-1:0]       wmask_i,
    input  logic [AW-1:0]             waddr_i,
    input  logic [WIDTH*SEGMENTS-1:0] wdata_i,
    input  logic                      re_i,
    input  logic [AW-1:0]             raddr_i,
    output logic [WIDTH*SEGMENTS-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [WIDTH*SEGMENTS-1:0] mem_q [DEPTH];
    logic [WIDTH*SEGMENTS-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned s = 0; s < SEGMENTS; s++) begin
                if (wmask_i[s]) begin
                    mem_q[waddr_i][s*WIDTH +: WIDTH] <= wdata_i[s*WIDTH +: WIDTH];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/display_framebuffer.sv
// Double-buffered pixel frame store: composer writes the back bank, scan engine reads the front.
// Define CLEAR_ON_FLIP_EN to zero the new back bank in hardware after every swap.
module display_framebuffer
    import display_pkg::*;
#(
    parameter  int unsigned SEGMENTS = 1,
    parameter  int unsigned ROWS     = 8,
    parameter  int unsigned COLUMNS  = 32,
    parameter  int unsigned WIDTH    = 24,
    localparam int unsigned RW       = idx_width(ROWS),
    localparam int unsigned CW       = idx_width(COLUMNS)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flip_req_i,
    output logic                      flip_busy_o,
    input  logic                      frame_end_i,
    output logic                      front_o,
    input  logic                      wen_i,
    input  logic [RW-1:0]             wrow_i,
    input  logic [CW-1:0]             wcol_i,
    input  logic [SEGMENTS-1:0]       wmask_i,
    input  logic [WIDTH*SEGMENTS-1:0] wdata_i,
    output logic                      wready_o,
    input  logic                      ren_i,
    input  logic [RW-1:0]             rrow_i,
    input  logic [CW-1:0]             rcol_i,
    output logic [WIDTH*SEGMENTS-1:0] rdata_o,
    output logic                      rvalid_o
);

    localparam int unsigned AW = BANK_AW + RW + CW;
    localparam int unsigned DW = WIDTH * SEGMENTS;
    localparam logic [RW:0] ROWS_L = (RW+1)'(ROWS);
    localparam logic [CW:0] COLS_L = (CW+1)'(COLUMNS);

    fb_state_e         state_q, state_d;
    logic              front_q, front_d;
    logic              busy_q;
    logic              rvalid_q;
    logic              rdZero_q;
    logic              wInRange, rInRange;
    logic              wready;
    logic              userWe;
    logic              ramWe;
    logic [SEGMENTS-1:0] ramMask;
    logic [AW-1:0]     ramWaddr, ramRaddr;
    logic [DW-1:0]     ramWdata, ramRdata;

    assign wInRange = ({1'b0, wrow_i} < ROWS_L) && ({1'b0, wcol_i} < COLS_L);
    assign rInRange = ({1'b0, rrow_i} < ROWS_L) && ({1'b0, rcol_i} < COLS_L);
    assign userWe   = wen_i && wready && wInRange;
    assign ramRaddr = {read_bank(front_q), rrow_i, rcol_i};

`ifdef CLEAR_ON_FLIP_EN
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLUMNS - 1);

    logic [RW-1:0] clrRow_q, clrRow_d;
    logic [CW-1:0] clrCol_q, clrCol_d;
    logic          clearing;
    logic          clrLast;

    assign clearing = (state_q == CLEAR);
    assign clrLast  = (clrRow_q == ROW_LAST) && (clrCol_q == COL_LAST);

    // Row-major walk; wraps back to (0,0) on the last address so the next clear starts clean.
    always_comb begin
        clrRow_d = clrRow_q;
        clrCol_d = clrCol_q;
        if (clearing) begin
            if (clrCol_q == COL_LAST) begin
                clrCol_d = '0;
                clrRow_d = (clrRow_q == ROW_LAST) ? '0 : clrRow_q + 1'b1;
            end else begin
                clrCol_d = clrCol_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clrRow_q <= '0;
            clrCol_q <= '0;
        end else begin
            clrRow_q <= clrRow_d;
            clrCol_q <= clrCol_d;
        end
    end

    assign wready   = ~clearing;
    assign ramWe    = clearing | userWe;
    assign ramWaddr = clearing ? {write_bank(front_q), clrRow_q, clrCol_q}
                               : {write_bank(front_q), wrow_i, wcol_i};
    assign ramMask  = clearing ? '1 : wmask_i;
    assign ramWdata = clearing ? '0 : wdata_i;
`else
    assign wready   = 1'b1;
    assign ramWe    = userWe;
    assign ramWaddr = {write_bank(front_q), wrow_i, wcol_i};
    assign ramMask  = wmask_i;
    assign ramWdata = wdata_i;
`endif

    // A flip request is only honoured from IDLE; the swap itself waits for a frame boundary.
    always_comb begin
        state_d = state_q;
        front_d = front_q;
        unique case (state_q)
            IDLE: begin
                if (flip_req_i) state_d = PENDING;
            end
            PENDING: begin
                if (frame_end_i) begin
                    front_d = ~front_q;
`ifdef CLEAR_ON_FLIP_EN
                    state_d = CLEAR;
`else
                    state_d = IDLE;
`endif
                end
            end
            CLEAR: begin
`ifdef CLEAR_ON_FLIP_EN
                if (clrLast) state_d = IDLE;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            front_q  <= FRONT_AT_RESET;
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdZero_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            front_q  <= front_d;
            busy_q   <= (state_d != IDLE);
            rvalid_q <= ren_i;
            if (ren_i) begin
                rdZero_q <= ~rInRange;
            end
        end
    end

    display_fb_ram #(
        .SEGMENTS (SEGMENTS),
        .WIDTH    (WIDTH),
        .AW       (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ramWe),
        .wmask_i (ramMask),
        .waddr_i (ramWaddr),
        .wdata_i (ramWdata),
        .re_i    (ren_i && rInRange),
        .raddr_i (ramRaddr),
        .rdata_o (ramRdata)
    );

    // The RAM output register has no reset, so reset and out-of-range reads are masked to zero here.
    assign rdata_o     = rdZero_q ? '0 : ramRdata;
    assign rvalid_o    = rvalid_q;
    assign front_o     = front_q;
    assign flip_busy_o = busy_q;
    assign wready_o    = wready;

endmodule

// File: tb/tb_display_framebuffer.sv
// Self-checking bench for display_framebuffer with SEGMENTS=2, ROWS=6, COLUMNS=7 (non-power-of-two).
// Expectations come from an array model of the two banks indexed by the modelled front index.
module tb_display_framebuffer;

    localparam int SEG   = 2;
    localparam int ROWS  = 6;
    localparam int COLS  = 7;
    localparam int WIDTH = 24;
    localparam int DW    = WIDTH * SEG;
`ifdef CLEAR_ON_FLIP_EN
    localparam int EXP_CLEAR = ROWS * COLS;
`else
    localparam int EXP_CLEAR = 0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flip_req, flip_busy, frame_end, front;
    logic            wen, wready, ren, rvalid;
    logic [2:0]      wrow, wcol, rrow, rcol;
    logic [SEG-1:0]  wmask;
    logic [DW-1:0]   wdata, rdata;

    always #5 clk = ~clk;

    display_framebuffer #(
        .SEGMENTS (SEG),
        .ROWS     (ROWS),
        .COLUMNS  (COLS),
        .WIDTH    (WIDTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flip_req_i  (flip_req),
        .flip_busy_o (flip_busy),
        .frame_end_i (frame_end),
        .front_o     (front),
        .wen_i       (wen),
        .wrow_i      (wrow),
        .wcol_i      (wcol),
        .wmask_i     (wmask),
        .wdata_i     (wdata),
        .wready_o    (wready),
        .ren_i       (ren),
        .rrow_i      (rrow),
        .rcol_i      (rcol),
        .rdata_o     (rdata),
        .rvalid_o    (rvalid)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    logic [WIDTH-1:0] mdlMem   [2][8][8][SEG];
    bit               mdlKnown [2][8][8][SEG];
    bit               mdlFront;

    function automatic logic [DW-1:0] mdlRead(input int r, input int c, output bit ok);
        logic [DW-1:0] v = '0;
        int b = mdlFront ? 1 : 0;
        ok = 1'b1;
        if (r >= ROWS || c >= COLS) return '0;
        for (int s = 0; s < SEG; s++) begin
            v[s*WIDTH +: WIDTH] = mdlMem[b][r][c][s];
            if (!mdlKnown[b][r][c][s]) ok = 1'b0;
        end
        return v;
    endfunction

    function automatic void mdlWrite(input int r, input int c, input logic [SEG-1:0] m,
                                     input logic [DW-1:0] d);
        int b = mdlFront ? 0 : 1;
        if (r >= ROWS || c >= COLS) return;
        for (int s = 0; s < SEG; s++) begin
            if (m[s]) begin
                mdlMem[b][r][c][s]   = d[s*WIDTH +: WIDTH];
                mdlKnown[b][r][c][s] = 1'b1;
            end
        end
    endfunction

    function automatic void mdlZeroBank(input int b);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                for (int s = 0; s < SEG; s++) begin
                    mdlMem[b][r][c][s]   = '0;
                    mdlKnown[b][r][c][s] = 1'b1;
                end
    endfunction

    function automatic void mdlForget();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    for (int s = 0; s < SEG; s++) mdlKnown[b][r][c][s] = 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doWrite(input int r, input int c, input logic [SEG-1:0] m, input logic [DW-1:0] d);
        wen = 1'b1; wrow = 3'(r); wcol = 3'(c); wmask = m; wdata = d;
        tick();
        wen = 1'b0;
        mdlWrite(r, c, m, d);
    endtask

    task automatic doRead(input int r, input int c, output logic [DW-1:0] data, output logic valid);
        ren = 1'b1; rrow = 3'(r); rcol = 3'(c);
        tick();
        ren = 1'b0;
        data  = rdata;
        valid = rvalid;
    endtask

    task automatic pulseFlipReq();
        flip_req = 1'b1;
        tick();
        flip_req = 1'b0;
    endtask

    task automatic pulseFrameEnd();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    // Counts cycles with wready low after a swap; bounded so a stuck clear still ends the run.
    task automatic waitClear(output int lowCycles);
        lowCycles = 0;
        while (wready !== 1'b1 && lowCycles < 2000) begin
            lowCycles++;
            tick();
        end
`ifdef CLEAR_ON_FLIP_EN
        mdlZeroBank(mdlFront ? 0 : 1);
`endif
    endtask

    task automatic doFlip(output int lowCycles, output logic frontSeen, output logic busySeen);
        pulseFlipReq();
        tick();
        pulseFrameEnd();
        mdlFront = ~mdlFront;
        frontSeen = front;
        waitClear(lowCycles);
        busySeen = flip_busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        nCompared++; if (front !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_front: got %b expected 0", front); end
        nCompared++; if (flip_busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", flip_busy); end
        nCompared++; if (wready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_wready: got %b expected 1", wready); end
        nCompared++; if (rvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rvalid: got %b expected 0", rvalid); end
        nCompared++; if (rdata !== '0) begin nMismatched++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_flip_read();
        int low; logic f, b; logic [DW-1:0] exp; bit ok;
        doWrite(2, 5, 2'b11, 48'h000000_ABCDEF);
        doFlip(low, f, b);
        nCompared++; if (f !== mdlFront) begin nMismatched++; $display("[TB] FAIL wfr_front: got %b expected %b", f, mdlFront); end
        nCompared++; if (low != EXP_CLEAR) begin nMismatched++; $display("[TB] FAIL wfr_clear_len: got %0d expected %0d", low, EXP_CLEAR); end
        nCompared++; if (b !== 1'b0) begin nMismatched++; $display("[TB] FAIL wfr_busy_after: got %b expected 0", b); end
        exp = mdlRead(2, 5, ok);
        ren = 1'b1; rrow = 3'd2; rcol = 3'd5;
        nCompared++; if (rvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL wfr_rvalid_before: got %b expected 0", rvalid); end
        tick();
        ren = 1'b0;
        nCompared++; if (rvalid !== 1'b1) begin nMismatched++; $display("[TB] FAIL wfr_rvalid: got %b expected 1", rvalid); end
        nCompared++; if (!ok || rdata !== exp) begin nMismatched++; $display("[TB] FAIL wfr_rdata: got %h expected %h", rdata, exp); end
        tick();
        nCompared++; if (rvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL wfr_rvalid_drop: got %b expected 0", rvalid); end
        nCompared++; if (rdata !== exp) begin nMismatched++; $display("[TB] FAIL wfr_rdata_hold: got %h expected %h", rdata, exp); end
    endtask

    task automatic test_mask();
        int low; logic f, b, v; logic [DW-1:0] exp, got; bit ok;
        doWrite(1, 1, 2'b11, 48'h111111_222222);
        doWrite(1, 1, 2'b01, 48'h333333_444444);
        doFlip(low, f, b);
        nCompared++; if (f !== mdlFront) begin nMismatched++; $display("[TB] FAIL mask_front: got %b expected %b", f, mdlFront); end
        exp = mdlRead(1, 1, ok);
        doRead(1, 1, got, v);
        nCompared++; if (!ok || got !== exp) begin nMismatched++; $display("[TB] FAIL mask_rdata: got %h expected %h", got, exp); end
        nCompared++; if (v !== 1'b1) begin nMismatched++; $display("[TB] FAIL mask_rvalid: got %b expected 1", v); end
    endtask

    task automatic test_flip_handshake();
        int low;
        pulseFlipReq();
        nCompared++; if (flip_busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL hs_busy_pending: got %b expected 1", flip_busy); end
        pulseFlipReq();
        tick();
        nCompared++; if (front !== mdlFront) begin nMismatched++; $display("[TB] FAIL hs_no_early_toggle: got %b expected %b", front, mdlFront); end
        pulseFrameEnd();
        mdlFront = ~mdlFront;
        nCompared++; if (front !== mdlFront) begin nMismatched++; $display("[TB] FAIL hs_toggle: got %b expected %b", front, mdlFront); end
        waitClear(low);
        nCompared++; if (low != EXP_CLEAR) begin nMismatched++; $display("[TB] FAIL hs_clear_len: got %0d expected %0d", low, EXP_CLEAR); end
        nCompared++; if (flip_busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL hs_busy_done: got %b expected 0", flip_busy); end
        pulseFrameEnd();
        nCompared++; if (front !== mdlFront) begin nMismatched++; $display("[TB] FAIL hs_not_queued: got %b expected %b", front, mdlFront); end
        flip_req = 1'b1; frame_end = 1'b1;
        tick();
        flip_req = 1'b0; frame_end = 1'b0;
        nCompared++; if (front !== mdlFront) begin nMismatched++; $display("[TB] FAIL hs_simul_no_toggle: got %b expected %b", front, mdlFront); end
        nCompared++; if (flip_busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL hs_simul_busy: got %b expected 1", flip_busy); end
        tick();
        pulseFrameEnd();
        mdlFront = ~mdlFront;
        nCompared++; if (front !== mdlFront) begin nMismatched++; $display("[TB] FAIL hs_simul_toggle: got %b expected %b", front, mdlFront); end
        waitClear(low);
        nCompared++; if (flip_busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL hs_simul_done: got %b expected 0", flip_busy); end
    endtask

    task automatic test_range();
        int low; logic f, b, v; logic [DW-1:0] exp, got; bit ok;
        doWrite(0, 0, 2'b11, 48'h5A5A5A_C3C3C3);
        doWrite(5, 6, 2'b11, 48'h0F0F0F_F0F0F0);
        doWrite(7, 2, 2'b11, 48'hFFFFFF_FFFFFF);
        doWrite(3, 7, 2'b11, 48'hFFFFFF_FFFFFF);
        doFlip(low, f, b);
        exp = mdlRead(5, 6, ok);
        doRead(5, 6, got, v);
        nCompared++; if (!ok || got !== exp) begin nMismatched++; $display("[TB] FAIL range_last_cell: got %h expected %h", got, exp); end
        exp = mdlRead(0, 0, ok);
        doRead(0, 0, got, v);
        nCompared++; if (!ok || got !== exp) begin nMismatched++; $display("[TB] FAIL range_first_cell: got %h expected %h", got, exp); end
        exp = mdlRead(7, 2, ok);
        doRead(7, 2, got, v);
        nCompared++; if (got !== exp) begin nMismatched++; $display("[TB] FAIL range_row7_read: got %h expected %h", got, exp); end
        nCompared++; if (v !== 1'b1) begin nMismatched++; $display("[TB] FAIL range_row7_rvalid: got %b expected 1", v); end
        tick();
        nCompared++; if (rdata !== exp) begin nMismatched++; $display("[TB] FAIL range_hold_zero: got %h expected %h", rdata, exp); end
        exp = mdlRead(3, 7, ok);
        doRead(3, 7, got, v);
        nCompared++; if (got !== exp) begin nMismatched++; $display("[TB] FAIL range_col7_read: got %h expected %h", got, exp); end
    endtask

    task automatic test_toggle_read();
        int low; logic f, b, v; logic [DW-1:0] expOld, exp, got; bit okOld, ok;
        doWrite(3, 3, 2'b11, 48'hAAAAAA_000001);
        doFlip(low, f, b);
        doWrite(3, 3, 2'b11, 48'hBBBBBB_000002);
        pulseFlipReq();
        expOld = mdlRead(3, 3, okOld);
        frame_end = 1'b1;
        ren = 1'b1; rrow = 3'd3; rcol = 3'd3;
        wen = 1'b1; wrow = 3'd4; wcol = 3'd4; wmask = 2'b11; wdata = 48'hCCCCCC_000003;
        tick();
        frame_end = 1'b0; ren = 1'b0; wen = 1'b0;
        mdlWrite(4, 4, 2'b11, 48'hCCCCCC_000003);
        mdlFront = ~mdlFront;
        nCompared++; if (!okOld || rdata !== expOld) begin nMismatched++; $display("[TB] FAIL tog_read_old_front: got %h expected %h", rdata, expOld); end
        nCompared++; if (front !== mdlFront) begin nMismatched++; $display("[TB] FAIL tog_front: got %b expected %b", front, mdlFront); end
        waitClear(low);
        exp = mdlRead(4, 4, ok);
        doRead(4, 4, got, v);
        nCompared++; if (!ok || got !== exp) begin nMismatched++; $display("[TB] FAIL tog_write_lands: got %h expected %h", got, exp); end
        exp = mdlRead(3, 3, ok);
        doRead(3, 3, got, v);
        nCompared++; if (!ok || got !== exp) begin nMismatched++; $display("[TB] FAIL tog_back_data: got %h expected %h", got, exp); end
    endtask

    task automatic test_random(input int iters);
        int low, r, c, wr, wc; logic f, b, v; logic [DW-1:0] exp, lastExp, got, d;
        logic [SEG-1:0] m; bit ok, lastOk, issued, doW;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) doWrite(i, j, 2'b11, DW'({$urandom(), $urandom()}));
        doFlip(low, f, b);
        nCompared++; if (f !== mdlFront) begin nMismatched++; $display("[TB] FAIL rand_flip_front: got %b expected %b", f, mdlFront); end
        lastOk = 1'b0; lastExp = '0;
        for (int i = 0; i < iters; i++) begin
            issued = 1'($urandom_range(0, 1));
            doW    = 1'($urandom_range(0, 1));
            r  = ($urandom_range(0, 9) == 0) ? ROWS + int'($urandom_range(0, 1)) : int'($urandom_range(0, ROWS-1));
            c  = ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, COLS-1));
            wr = int'($urandom_range(0, 7));
            wc = int'($urandom_range(0, 7));
            m  = SEG'($urandom_range(0, 3));
            d  = DW'({$urandom(), $urandom()});
            exp = mdlRead(r, c, ok);
            ren = issued; rrow = 3'(r); rcol = 3'(c);
            wen = doW; wrow = 3'(wr); wcol = 3'(wc); wmask = m; wdata = d;
            tick();
            ren = 1'b0; wen = 1'b0;
            if (doW) mdlWrite(wr, wc, m, d);
            nCompared++; if (rvalid !== issued) begin nMismatched++; $display("[TB] FAIL rand_rvalid: got %b expected %b", rvalid, issued); end
            if (issued) begin
                if (ok) begin
                    nCompared++; if (rdata !== exp) begin nMismatched++; $display("[TB] FAIL rand_rdata (%0d,%0d): got %h expected %h", r, c, rdata, exp); end
                end
                lastOk = ok; lastExp = exp;
            end else if (lastOk) begin
                nCompared++; if (rdata !== lastExp) begin nMismatched++; $display("[TB] FAIL rand_hold: got %h expected %h", rdata, lastExp); end
            end
        end
        doFlip(low, f, b);
        for (int i = 0; i < 16; i++) begin
            r = int'($urandom_range(0, ROWS-1));
            c = int'($urandom_range(0, COLS-1));
            exp = mdlRead(r, c, ok);
            doRead(r, c, got, v);
            if (ok) begin
                nCompared++; if (got !== exp) begin nMismatched++; $display("[TB] FAIL rand_after_flip (%0d,%0d): got %h expected %h", r, c, got, exp); end
            end
        end
    endtask

`ifdef CLEAR_ON_FLIP_EN
    task automatic test_clear();
        int low; logic f, b, v; logic [DW-1:0] exp, got; bit ok;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) doWrite(i, j, 2'b11, DW'({$urandom(), $urandom()}) | 48'h1);
        doFlip(low, f, b);
        nCompared++; if (low != EXP_CLEAR) begin nMismatched++; $display("[TB] FAIL clr_len1: got %0d expected %0d", low, EXP_CLEAR); end
        nCompared++; if (b !== 1'b0) begin nMismatched++; $display("[TB] FAIL clr_busy_with_wready: got %b expected 0", b); end
        doFlip(low, f, b);
        nCompared++; if (low != EXP_CLEAR) begin nMismatched++; $display("[TB] FAIL clr_len2: got %0d expected %0d", low, EXP_CLEAR); end
        for (int k = 0; k < 3; k++) begin
            exp = mdlRead(k * 2 + 1, k * 3, ok);
            doRead(k * 2 + 1, k * 3, got, v);
            nCompared++; if (!ok || got !== exp) begin nMismatched++; $display("[TB] FAIL clr_zero_read: got %h expected %h", got, exp); end
        end
        doWrite(0, 0, 2'b11, 48'h123456_789ABC);
        pulseFlipReq();
        pulseFrameEnd();
        mdlFront = ~mdlFront;
        repeat (5) tick();
        exp = mdlRead(0, 0, ok);
        doRead(0, 0, got, v);
        nCompared++; if (!ok || got !== exp) begin nMismatched++; $display("[TB] FAIL clr_read_during: got %h expected %h", got, exp); end
        nCompared++; if (wready !== 1'b0) begin nMismatched++; $display("[TB] FAIL clr_wready_low: got %b expected 0", wready); end
        ren = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        nCompared++; if (front !== 1'b0) begin nMismatched++; $display("[TB] FAIL midclr_front: got %b expected 0", front); end
        nCompared++; if (flip_busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL midclr_busy: got %b expected 0", flip_busy); end
        nCompared++; if (wready !== 1'b1) begin nMismatched++; $display("[TB] FAIL midclr_wready: got %b expected 1", wready); end
        nCompared++; if (rvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL midclr_rvalid: got %b expected 0", rvalid); end
        nCompared++; if (rdata !== '0) begin nMismatched++; $display("[TB] FAIL midclr_rdata: got %h expected 0", rdata); end
        ren = 1'b0;
        mdlForget();
        mdlFront = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask
`endif

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flip_req = 1'b0; frame_end = 1'b0;
        wen = 1'b0; wrow = '0; wcol = '0; wmask = '0; wdata = '0;
        ren = 1'b0; rrow = '0; rcol = '0;
        mdlFront = 1'b0;
        mdlForget();
        test_reset();
        test_write_flip_read();
        test_mask();
        test_flip_handshake();
        test_range();
        test_toggle_read();
        test_random(200);
`ifdef CLEAR_ON_FLIP_EN
        test_clear();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
